// File: rtl/uart_frame_assembler_if.sv
// Byte stream from the UART receiver into the frame assembler.
// The receiver drives byte and valid; the assembler returns ready.
interface uart_frame_assembler_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_byte, output rx_valid, input rx_ready);
    modport slave  (input rx_byte, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_frame_assembler.sv
// Assembles 7-byte LED-array frames (header, letter, 5 alphanumerics) from the UART byte stream,
// decodes ASCII to glyph indices and commits the 56-bit frame atomically.
module uart_frame_assembler #(
    parameter int CLK_FRE    = 50,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_frame_assembler_if.slave        rx,
    output logic [55:0]                  frame_data,
    output logic                         light,
    output logic                         frame_valid,
    output logic                         frame_err,
    output logic [15:0]                  frame_cnt
);

    localparam int          TIMEOUT_CYC = CLK_FRE * TIMEOUT_US;
    localparam logic [23:0] GAP_LAST    = 24'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        WAIT_HDR,
        COLLECT,
        COMMIT
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [23:0] gap_cnt;
    logic [55:0] shadow;
    logic        shadow_light;

    logic        accept;
    logic        is_digit;
    logic        is_upper;
    logic        char_ok;
    logic [7:0]  char_val;

    always_comb begin
        accept   = rx.rx_valid && rx.rx_ready;
        is_digit = (rx.rx_byte >= 8'h30) && (rx.rx_byte <= 8'h39);
        is_upper = (rx.rx_byte >= 8'h41) && (rx.rx_byte <= 8'h5A);
        // The first payload byte must be a letter; the rest may also be digits.
        char_ok  = (idx == 3'd1) ? is_upper : (is_upper || is_digit);
        char_val = is_digit ? 8'(rx.rx_byte - 8'h30) : 8'(rx.rx_byte - 8'd55);
    end

    // NOTE: the reset branch clears every register, shadow included, so an aborted or
    // reset-interrupted frame can never leak into a later commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_HDR;
            idx          <= 3'd0;
            gap_cnt      <= 24'd0;
            shadow       <= 56'd0;
            shadow_light <= 1'b0;
            frame_data   <= 56'd0;
            light        <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= 16'd0;
            rx.rx_ready  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            rx.rx_ready <= 1'b1;
            case (state)
                WAIT_HDR: begin
                    if (accept) begin
                        if (rx.rx_byte[6:0] >= 7'h40) begin
                            shadow[55:48] <= 8'({1'b0, rx.rx_byte[6:0]} - 8'h40);
                            shadow_light  <= rx.rx_byte[7];
                            idx           <= 3'd1;
                            gap_cnt       <= 24'd0;
                            state         <= COLLECT;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        gap_cnt <= 24'd0;
                        if (char_ok) begin
                            shadow[8*(6-int'(idx)) +: 8] <= char_val;
                            if (idx == 3'd6) begin
                                state       <= COMMIT;
                                rx.rx_ready <= 1'b0;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HDR;
                        end
                    end else if (gap_cnt == GAP_LAST) begin
                        frame_err <= 1'b1;
                        state     <= WAIT_HDR;
                    end else begin
                        gap_cnt <= gap_cnt + 24'd1;
                    end
                end
                COMMIT: begin
                    frame_data  <= shadow;
                    light       <= shadow_light;
                    frame_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + 16'd1;
                    state       <= WAIT_HDR;
                end
                default: state <= WAIT_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench with a scoreboard: stimulus queues expected commits/errors, a negedge monitor
// pops and compares each frame_valid / frame_err pulse.
module tb_uart_frame_assembler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_assembler_if bus ();

    logic [55:0] frame_data;
    logic        light;
    logic        frame_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    uart_frame_assembler #(
        .CLK_FRE    (50),
        .TIMEOUT_US (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (bus),
        .frame_data  (frame_data),
        .light       (light),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    typedef struct {
        bit          is_err;
        logic [55:0] data;
        logic        light;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [55:0] RAW_A  = 56'hC1_42_31_32_41_5A_30;
    localparam logic [55:0] EXP_A  = 56'h01_0B_01_02_0A_23_00;
    localparam logic [55:0] RAW_B  = 56'h41_43_35_39_51_58_37;
    localparam logic [55:0] EXP_B  = 56'h01_0C_05_09_1A_21_07;
    localparam logic [55:0] RAW_C  = 56'h7F_5A_39_30_41_42_43;
    localparam logic [55:0] EXP_C  = 56'h3F_23_09_00_0A_0B_0C;

    exp_t        exp_q[$];
    int          checks    = 0;
    int          errors    = 0;
    logic [15:0] exp_cnt   = 16'd0;
    bit          win       = 1'b0;
    int          ready_low = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [55:0] data, input logic lt);
        exp_t e;
        exp_cnt  = exp_cnt + 16'd1;
        e.is_err = 1'b0;
        e.data   = data;
        e.light  = lt;
        e.cnt    = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        e.light  = 1'b0;
        e.cnt    = '0;
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; returns just after the edge that accepted the byte.
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        while (!bus.rx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: rx_ready stayed 0 for %0d cycles, byte %0h", n, b);
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [55:0] raw);
        for (int i = 0; i < 7; i++) send(raw[55-8*i -: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (win && !bus.rx_ready) ready_low++;
        if (!rst && (frame_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {62'd0, frame_err, frame_valid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_kind_err", frame_err, e.is_err);
                if (!e.is_err) begin
                    check("commit_data", frame_data, e.data);
                    check("commit_light", light, e.light);
                    check("commit_cnt", frame_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        idle(3);
        check("rst_frame_data", frame_data, 0);
        check("rst_light", light, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_rx_ready", bus.rx_ready, 0);
        rst = 1'b0;
        idle(1);
        check("ready_after_rst", bus.rx_ready, 1);

        // Basic frame
        expect_frame(EXP_A, 1'b1);
        send_frame(RAW_A);
        idle(3);
        check("t1_cnt", frame_cnt, 1);
        check("t1_data", frame_data, EXP_A);

        // Bad header, then a good frame
        expect_err();
        send(8'h20);
        idle(2);
        expect_frame(EXP_A, 1'b1);
        send_frame(RAW_A);
        idle(3);
        check("t2_cnt", frame_cnt, 2);

        // Bad character aborts without touching the committed frame
        expect_err();
        send(8'h41); send(8'h43); send(8'h35); send(8'h23);
        idle(3);
        check("t3_data_kept", frame_data, EXP_A);
        check("t3_light_kept", light, 1);
        check("t3_cnt_kept", frame_cnt, 2);
        expect_frame(EXP_B, 1'b0);
        send_frame(RAW_B);
        idle(3);
        check("t3_data", frame_data, EXP_B);

        // Byte arriving as the gap counter hits its last value wins
        send(8'h7F); send(8'h5A); send(8'h39);
        idle(49);
        expect_frame(EXP_C, 1'b0);
        send(8'h30); send(8'h41); send(8'h42); send(8'h43);
        idle(3);
        check("t4_cnt", frame_cnt, 4);

        // Idle gap of a full timeout aborts
        send(8'hFF); send(8'h4D); send(8'h30);
        idle(49);
        check("t4_no_early_timeout", frame_err, 0);
        expect_err();
        idle(1);
        check("t4_timeout_err", frame_err, 1);
        idle(3);
        check("t4_data_kept", frame_data, EXP_C);

        // Reset mid-frame
        send(8'hC1); send(8'h42); send(8'h31); send(8'h32);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_data", frame_data, 0);
        check("t5_rst_cnt", frame_cnt, 0);
        check("t5_rst_light", light, 0);
        check("t5_rst_ready", bus.rx_ready, 0);
        exp_cnt = 16'd0;
        idle(2);
        rst = 1'b0;
        idle(1);
        check("t5_ready_after_rst", bus.rx_ready, 1);
        expect_frame(EXP_B, 1'b0);
        send_frame(RAW_B);
        idle(3);
        check("t5_cnt", frame_cnt, 1);

        // rx_valid held across two back-to-back frames
        win = 1'b1;
        expect_frame(EXP_A, 1'b1);
        expect_frame(EXP_C, 1'b0);
        send_frame(RAW_A);
        send_frame(RAW_C);
        idle(4);
        win = 1'b0;
        check("t6_ready_low_cycles", ready_low, 2);
        check("t6_cnt", frame_cnt, 3);
        check("t6_data", frame_data, EXP_C);

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
